// File: rtl/memory_arbiter.sv
// Purpose : shares one single-ported RAM between an instruction-fetch port and a data port.
// Latency : request seen in IDLE cycle N, ram_done in cycle N+k (k>=1), ready pulse in cycle N+k+1.
// Backpr. : requesters hold their request until their one-cycle ready pulse; RAM stalls via ram_done.
// Ports   : clk/rst (sync, active-high); i_* fetch port; d_* data port; ram_* memory side;
//           state exposes the current ram_state_t encoding.
module memory_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_strobe,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_strobe,
    input  logic [31:0] ram_rdata,
    input  logic        ram_done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_WAIT = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    ram_state_t    state_q, state_n;
    logic [CW-1:0] starve_q;
    logic          own_i_q;     // 1: current access belongs to the fetch port
    logic          wr_q;        // 1: current access is a data write
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    strobe_q;
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;

    logic d_any;
    logic pick_i;
    logic grant;
    logic in_wait;

    assign d_any = d_ren | d_wen;
    // Data normally wins; the fetch port only overrides once it has been passed over LIMIT times.
    assign pick_i = i_req & (~d_any | (starve_q == LIMIT));

    always_comb begin
        state_n = state_q;
        grant   = 1'b0;
        case (state_q)
            RAM_IDLE: begin
                if (i_req | d_any) begin
                    grant   = 1'b1;
                    state_n = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (ram_done) state_n = RAM_DONE;
            end
            RAM_DONE: state_n = RAM_IDLE;
            default:  state_n = RAM_IDLE;   // unused encoding 3 recovers immediately
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RAM_IDLE;
            starve_q  <= '0;
            own_i_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strobe_q  <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_n;
            if (grant) begin
                own_i_q  <= pick_i;
                // A simultaneous read+write request is served as a write.
                wr_q     <= ~pick_i & d_wen;
                addr_q   <= pick_i ? i_addr : d_addr;
                wdata_q  <= (~pick_i & d_wen) ? d_wdata : 32'd0;
                strobe_q <= (~pick_i & d_wen) ? d_strobe : 4'b1111;
                if (pick_i || !i_req) begin
                    starve_q <= '0;
                end else if (starve_q != LIMIT) begin
                    starve_q <= starve_q + 1'b1;
                end
            end
            if (state_q == RAM_WAIT && ram_done) begin
                if (own_i_q) i_rdata_q <= ram_rdata;
                else         d_rdata_q <= wr_q ? 32'd0 : ram_rdata;
            end
        end
    end

    // RAM side is driven purely from the latched request while waiting, zero otherwise.
    assign in_wait    = (state_q == RAM_WAIT);
    assign ram_ren    = in_wait & ~wr_q;
    assign ram_wen    = in_wait & wr_q;
    assign ram_addr   = in_wait ? addr_q   : 32'd0;
    assign ram_wdata  = in_wait ? wdata_q  : 32'd0;
    assign ram_strobe = in_wait ? strobe_q : 4'd0;

    assign i_ready = (state_q == RAM_DONE) & own_i_q;
    assign d_ready = (state_q == RAM_DONE) & ~own_i_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign state   = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_ren, d_wen;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_strobe;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        ram_ren, ram_wen;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_strobe;
    logic [31:0] ram_rdata;
    logic        ram_done;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    memory_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_strobe(d_strobe), .d_ready(d_ready), .d_rdata(d_rdata),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_strobe(ram_strobe),
        .ram_rdata(ram_rdata), .ram_done(ram_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 0; i_addr = 0; d_ren = 0; d_wen = 0;
        d_addr = 0; d_wdata = 0; d_strobe = 0; ram_rdata = 0; ram_done = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        chk("rst_ram_en", {30'd0, ram_ren, ram_wen}, 32'd0);
        chk("rst_rdata", i_rdata | d_rdata, 32'd0);

        // Single fetch: request in cycle 0, ram_done in cycle 2, ready in cycle 3.
        i_req = 1; i_addr = 32'h100;
        tick();
        chk("f_c1_state", {30'd0, state}, 32'd1);
        chk("f_c1_ren", {30'd0, ram_ren, ram_wen}, 32'd2);
        chk("f_c1_addr", ram_addr, 32'h100);
        chk("f_c1_strobe", {28'd0, ram_strobe}, 32'hF);
        chk("f_c1_wdata", ram_wdata, 32'd0);
        tick();
        chk("f_c2_state", {30'd0, state}, 32'd1);
        ram_done = 1; ram_rdata = 32'h13;
        tick();
        chk("f_c3_iready", {30'd0, i_ready, d_ready}, 32'd2);
        chk("f_c3_irdata", i_rdata, 32'h13);
        chk("f_c3_ren", {31'd0, ram_ren}, 32'd0);
        i_req = 0; ram_done = 0;
        tick();
        chk("f_c4_state", {30'd0, state}, 32'd0);
        chk("f_c4_iready", {31'd0, i_ready}, 32'd0);
        chk("f_c4_hold", i_rdata, 32'h13);

        // Simultaneous fetch and data read with counter 0: data first.
        i_req = 1; i_addr = 32'h200; d_ren = 1; d_addr = 32'h40;
        tick();
        chk("p_wait_addr_d", ram_addr, 32'h40);
        ram_done = 1; ram_rdata = 32'hAAAA0001;
        tick();
        chk("p_dready", {30'd0, i_ready, d_ready}, 32'd1);
        chk("p_drdata", d_rdata, 32'hAAAA0001);
        d_ren = 0; ram_done = 0;
        tick();
        chk("p_idle", {30'd0, state}, 32'd0);
        tick();
        chk("p_wait_addr_i", ram_addr, 32'h200);
        ram_done = 1; ram_rdata = 32'h13572468;
        tick();
        chk("p_iready", {30'd0, i_ready, d_ready}, 32'd2);
        chk("p_irdata", i_rdata, 32'h13572468);
        chk("p_dhold", d_rdata, 32'hAAAA0001);
        i_req = 0; ram_done = 0;
        tick();

        // Starvation: both held continuously, ram_done held high.
        i_req = 1; i_addr = 32'h300; d_ren = 1; d_addr = 32'h80;
        ram_done = 1; ram_rdata = 32'h11112222;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("s%0d_addr", k), ram_addr, (k < 4) ? 32'h80 : 32'h300);
            tick();
            chk($sformatf("s%0d_ready", k), {30'd0, i_ready, d_ready}, (k < 4) ? 32'd1 : 32'd2);
            tick();
        end
        // Counter cleared by the fetch grant, so data wins again.
        tick();
        chk("s5_addr_after_clear", ram_addr, 32'h80);
        i_req = 0; d_ren = 0;
        tick();
        chk("s5_dready", {30'd0, i_ready, d_ready}, 32'd1);
        ram_done = 0;
        tick();

        // Write (with d_ren also set -> write only), done after 5 WAIT cycles.
        d_wen = 1; d_ren = 1; d_strobe = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h2000;
        ram_rdata = 32'hFFFFFFFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w%0d_en", i), {30'd0, ram_ren, ram_wen}, 32'd1);
            chk($sformatf("w%0d_addr", i), ram_addr, 32'h2000);
            chk($sformatf("w%0d_wdata", i), ram_wdata, 32'hDEADBEEF);
            chk($sformatf("w%0d_strobe", i), {28'd0, ram_strobe}, 32'h3);
            d_addr = 32'h5555; d_wdata = 32'h0; d_strobe = 4'b1100;
            if (i == 4) ram_done = 1;
            tick();
        end
        chk("w_dready", {30'd0, i_ready, d_ready}, 32'd1);
        chk("w_drdata", d_rdata, 32'd0);
        chk("w_done_en", {30'd0, ram_ren, ram_wen}, 32'd0);
        d_wen = 0; d_ren = 0; ram_done = 0;
        tick();
        chk("w_single_pulse", {31'd0, d_ready}, 32'd0);
        chk("w_drdata_hold", d_rdata, 32'd0);

        // Reset in the middle of a WAIT; late ram_done must be ignored.
        i_req = 1; i_addr = 32'h400;
        tick();
        chk("r_wait_ren", {31'd0, ram_ren}, 32'd1);
        rst = 1;
        tick();
        chk("r_state", {30'd0, state}, 32'd0);
        chk("r_en", {30'd0, ram_ren, ram_wen}, 32'd0);
        chk("r_irdata_clr", i_rdata, 32'd0);
        rst = 0; i_req = 0; ram_done = 1; ram_rdata = 32'h77777777;
        tick();
        chk("r_late_state", {30'd0, state}, 32'd0);
        chk("r_late_ready", {30'd0, i_ready, d_ready}, 32'd0);

        // Stray ram_done in IDLE with no request.
        tick();
        chk("x_state", {30'd0, state}, 32'd0);
        chk("x_ready", {30'd0, i_ready, d_ready}, 32'd0);
        chk("x_rdata", i_rdata | d_rdata, 32'd0);
        ram_done = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_req  in  1  instruction fetch read request, held until i_ready.
REQ-005 i_addr  in  32  fetch address (word_t).
REQ-006 i_ready  out  1  fetch complete, one-cycle pulse.
REQ-007 i_rdata  out  32  fetch data, valid when i_ready.
REQ-008 d_ren  in  1  data read request, held until d_ready.
REQ-009 d_wen  in  1  data write request, held until d_ready.
REQ-010 d_addr  in  32  data address.
REQ-011 d_wdata  in  32  write data.
REQ-012 d_strobe  in  4  write byte enables.
REQ-013 d_ready  out  1  data access complete, one-cycle pulse.
REQ-014 d_rdata  out  32  read data, valid when d_ready.
REQ-015 ram_ren  out  1  RAM read enable.
REQ-016 ram_wen  out  1  RAM write enable.
REQ-017 ram_addr  out  32  RAM address.
REQ-018 ram_wdata  out  32  RAM write data.
REQ-019 ram_strobe  out  4  RAM byte enables.
REQ-020 ram_rdata  in  32  RAM read data, valid with ram_done.
REQ-021 ram_done  in  1  RAM access complete.
REQ-022 state  out  2  current ram_state_t (RAM_IDLE=0, RAM_WAIT=1, RAM_DONE=2).

Function
REQ-023 FSM states RAM_IDLE, RAM_WAIT, RAM_DONE; encoding 3 unused, recovers to RAM_IDLE next cycle.
REQ-024 RAM_IDLE: any request pending -> latch owner, op, addr, wdata, strobe; go RAM_WAIT; none -> stay.
REQ-025 Priority: data wins over instruction, except instruction wins when i_req=1 and starve counter == STARVE_LIMIT.
REQ-026 Starve counter: +1 on data grant with i_req=1 (saturating at STARVE_LIMIT); cleared on instruction grant or data grant with i_req=0.
REQ-027 d_ren=1 and d_wen=1 together: treated as write only.
REQ-028 RAM_WAIT: ram_* driven from latched registers only, stable every cycle until ram_done; input changes ignored.
REQ-029 Instruction grant: ram_ren=1, ram_wen=0, ram_strobe=4'b1111, ram_wdata=0.
REQ-030 Data read: ram_ren=1, ram_wen=0, ram_strobe=4'b1111; data write: ram_wen=1, ram_ren=0, ram_strobe=latched d_strobe.
REQ-031 RAM_WAIT with ram_done=1: capture ram_rdata (zero for writes); go RAM_DONE.
REQ-032 RAM_DONE: ram_ren=ram_wen=0; owner's ready=1 for exactly this cycle with captured rdata; other ready=0; go RAM_IDLE.
REQ-033 Latency: request in IDLE cycle N, ram_done in cycle N+k (k>=1) -> ready in cycle N+k+1; min 3 cycles per access.
REQ-034 ram_done outside RAM_WAIT ignored.
REQ-035 i_ready and d_ready never simultaneously 1; at most one RAM access outstanding.
REQ-036 i_rdata/d_rdata hold last captured value outside ready pulses.

Reset
REQ-037 rst=1 at any edge: state=RAM_IDLE, starve counter=0, all outputs 0 next cycle, including mid-access.
REQ-038 Access abandoned by reset not retried; ram_done for it ignored.

Verification
REQ-039 Single fetch: i_req=1, i_addr=0x100, ram_done one cycle after ram_ren, ram_rdata=0x00000013 -> ram_ren cycle 1, i_ready=1 and i_rdata=0x00000013 cycle 3, ram_ren=0 cycle 3.
REQ-040 Simultaneous i_req and d_ren, counter 0 -> data granted first, d_ready precedes i_ready; fetch served next.
REQ-041 Starvation: d_ren held continuously, i_req held, STARVE_LIMIT=4 -> 4 data grants then 1 instruction grant, counter returns to 0.
REQ-042 Write: d_wen=1, d_strobe=4'b0011, d_wdata=0xDEADBEEF, d_addr=0x2000, ram_done after 5 WAIT cycles -> ram_wen/ram_addr/ram_wdata/ram_strobe stable all 5 cycles, d_ready pulse once, d_rdata=0.
REQ-043 Reset mid-WAIT: rst=1 during RAM_WAIT -> next cycle state=0, ram_ren/ram_wen=0; late ram_done produces no ready.
REQ-044 Stray ram_done in RAM_IDLE with no request -> no state change, no ready pulse.
